// File: rtl/l2_dram_tm_sched.sv
// l2_dram_tm_sched
// Timing-model DRAM channel scheduler. L2 miss and writeback requests are
// queued per partition, one modelled channel is shared round-robin, issue is
// throttled by per-partition frame credits and by the channel cycle time, and
// read completions are returned a fixed access time after issue. No data is
// moved; only timing is modelled.
module l2_dram_tm_sched #(
    parameter int NPART     = 8,
    parameter int TIDW      = 6,
    parameter int QDEPTH    = 4,
    parameter int NINFLIGHT = 8,
    parameter int PW        = 9,
    parameter int TSW       = 12
) (
    input  logic                     gclk,
    input  logic                     rstn,
    input  logic [PW-1:0]            cfg_access_time,
    input  logic [PW-1:0]            cfg_cycle_time,
    input  logic [NPART*PW-1:0]      cfg_credits,
    input  logic [PW-1:0]            cfg_frame_len,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [$clog2(NPART)-1:0] req_partitionid,
    input  logic [TIDW-1:0]          req_tid,
    input  logic                     req_writeback,
    input  logic [31:0]              req_addr,
    output logic                     resp_valid,
    output logic [TIDW-1:0]          resp_tid,
    output logic [$clog2(NPART)-1:0] resp_partitionid,
    output logic                     issue_valid,
    output logic [$clog2(NPART)-1:0] issue_partitionid,
    output logic                     issue_writeback,
    output logic [NPART-1:0]         part_blocked
);

    localparam int PIDW = $clog2(NPART);
    localparam int QAW  = $clog2(QDEPTH);
    localparam int IAW  = $clog2(NINFLIGHT);

    // Per-partition request queues (occupancy counter carries one extra bit).
    logic [QAW:0]     q_cnt [NPART];
    logic [QAW-1:0]   q_wr  [NPART];
    logic [QAW-1:0]   q_rd  [NPART];
    logic [TIDW-1:0]  q_tid [NPART][QDEPTH];
    logic             q_wb  [NPART][QDEPTH];

    // Frame credits and channel timers.
    logic [PW-1:0]    credit     [NPART];
    logic [PW-1:0]    eff_credit [NPART];
    logic [PW-1:0]    busy;
    logic [PW-1:0]    frame_cnt;
    logic [TSW-1:0]   ts;
    logic [PIDW-1:0]  rr_ptr;

    // In-flight read FIFO, ordered by issue.
    logic [TIDW-1:0]  if_tid  [NINFLIGHT];
    logic [PIDW-1:0]  if_part [NINFLIGHT];
    logic [TSW-1:0]   if_due  [NINFLIGHT];
    logic [IAW-1:0]   if_wr;
    logic [IAW-1:0]   if_rd;
    logic [IAW:0]     if_cnt;

    logic [NPART-1:0] head_wb;
    logic [NPART-1:0] cand;
    logic [NPART-1:0] push_vec;
    logic [NPART-1:0] pop_vec;
    logic [PIDW-1:0]  sel;
    logic [PIDW-1:0]  idx;
    logic [TIDW-1:0]  head_tid;
    logic             found;
    logic             issue;
    logic             rd_issue;
    logic             reload;
    logic             push;
    logic             resp_fire;
    logic             if_full;
    logic [PW-1:0]    cycle_load;
    logic [PW-1:0]    frame_last;
    logic [PW-1:0]    access_eff;

    // The line address is carried for statistics only; nothing here consumes it.
    logic unused_addr;
    assign unused_addr = ^req_addr;

    // Derived configuration values; zero fields are clamped to one cycle.
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        reload     = (frame_cnt == '0);
        cycle_load = (cfg_cycle_time == '0) ? '0 : cfg_cycle_time - 1'b1;
        frame_last = (cfg_frame_len == '0) ? '0 : cfg_frame_len - 1'b1;
        access_eff = (cfg_access_time == '0) ? PW'(1) : cfg_access_time;
        if_full    = if_cnt[IAW];
    end

    // Per-partition effective credit, head type, eligibility and blocked status.
    always_comb begin
        for (int p = 0; p < NPART; p++) begin
            eff_credit[p]   = reload ? cfg_credits[p*PW +: PW] : credit[p];
            head_wb[p]      = q_wb[p][q_rd[p]];
            cand[p]         = (q_cnt[p] != '0) && (eff_credit[p] != '0) &&
                              (head_wb[p] || !if_full);
            part_blocked[p] = (q_cnt[p] != '0) && (eff_credit[p] == '0);
        end
    end

    // Round-robin pick of the first candidate at or after rr_ptr.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = rr_ptr;
        for (int i = 0; i < NPART; i++) begin
            idx = rr_ptr + PIDW'(i);
            if (!found && cand[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        issue    = found && (busy == '0);
        rd_issue = issue && !head_wb[sel];
        head_tid = q_tid[sel][q_rd[sel]];
    end

    // Queue push/pop strobes, one bit per partition.
    always_comb begin
        for (int p = 0; p < NPART; p++) begin
            push_vec[p] = push && (req_partitionid == PIDW'(p));
            pop_vec[p]  = issue && (sel == PIDW'(p));
        end
    end

    assign req_ready         = rstn && !q_cnt[req_partitionid][QAW];
    assign push              = req_valid && req_ready;
    assign resp_fire         = (if_cnt != '0) && (if_due[if_rd] == ts);
    assign resp_valid        = resp_fire;
    assign resp_tid          = resp_fire ? if_tid[if_rd] : '0;
    assign resp_partitionid  = resp_fire ? if_part[if_rd] : '0;
    assign issue_valid       = issue;
    assign issue_partitionid = issue ? sel : '0;
    assign issue_writeback   = issue && head_wb[sel];

    // Queue pointers and occupancy.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            for (int p = 0; p < NPART; p++) begin
                q_cnt[p] <= '0;
                q_wr[p]  <= '0;
                q_rd[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NPART; p++) begin
                if (push_vec[p]) q_wr[p] <= q_wr[p] + 1'b1;
                if (pop_vec[p])  q_rd[p] <= q_rd[p] + 1'b1;
                if (push_vec[p] && !pop_vec[p])
                    q_cnt[p] <= q_cnt[p] + 1'b1;
                else if (!push_vec[p] && pop_vec[p])
                    q_cnt[p] <= q_cnt[p] - 1'b1;
            end
        end
    end

    // Queue payload write.
    // NOTE: payload arrays are not reset; the occupancy counters alone decide what is valid.
    always_ff @(posedge gclk) begin
        if (push) begin
            q_tid[req_partitionid][q_wr[req_partitionid]] <= req_tid;
            q_wb[req_partitionid][q_wr[req_partitionid]]  <= req_writeback;
        end
    end

    // Credit update: reload on frame start, minus one for the issuing partition.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            for (int p = 0; p < NPART; p++) credit[p] <= '0;
        end else begin
            for (int p = 0; p < NPART; p++) begin
                if (pop_vec[p]) credit[p] <= eff_credit[p] - 1'b1;
                else            credit[p] <= eff_credit[p];
            end
        end
    end

    // Timestamp, frame counter, channel busy pacing and round-robin pointer.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            ts        <= '0;
            frame_cnt <= '0;
            busy      <= '0;
            rr_ptr    <= '0;
        end else begin
            ts        <= ts + 1'b1;
            frame_cnt <= (frame_cnt >= frame_last) ? '0 : frame_cnt + 1'b1;
            if (issue) begin
                busy   <= cycle_load;
                rr_ptr <= sel + 1'b1;
            end else if (busy != '0) begin
                busy <= busy - 1'b1;
            end
        end
    end

    // In-flight FIFO pointers: push on read issue, pop on completion.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            if_wr  <= '0;
            if_rd  <= '0;
            if_cnt <= '0;
        end else begin
            if (rd_issue)  if_wr <= if_wr + 1'b1;
            if (resp_fire) if_rd <= if_rd + 1'b1;
            if (rd_issue && !resp_fire)
                if_cnt <= if_cnt + 1'b1;
            else if (!rd_issue && resp_fire)
                if_cnt <= if_cnt - 1'b1;
        end
    end

    // In-flight payload: thread, partition and wrapped completion timestamp.
    always_ff @(posedge gclk) begin
        if (rd_issue) begin
            if_tid[if_wr]  <= head_tid;
            if_part[if_wr] <= sel;
            if_due[if_wr]  <= ts + TSW'(access_eff);
        end
    end

endmodule

// File: doc/l2_dram_tm_sched.md
Name: l2_dram_tm_sched

Overview:
- Timing-model DRAM channel scheduler between the L2 timing model's miss/writeback output and the modelled memory controller.
- Queues L2 miss and writeback requests per partition, and arbitrates the single modelled channel with round-robin.
- Enforces per-partition Globally-Synchronized-Frame (GSF) credits, paces issue at the configured cycle time, and returns read completions after the configured access time.
- Purely a timing model: addresses are carried only for statistics; no data moves.

Parameters:
- NPART, 8, number of partitions (power of 2)
- TIDW, 6, thread-id width
- QDEPTH, 4, per-partition request FIFO depth (power of 2)
- NINFLIGHT, 8, max issued-but-uncompleted reads (power of 2)
- PW, 9, width of timing configuration fields (log2 of max miss penalty 512)
- TSW, 12, timestamp width (must exceed PW)

Ports:
- gclk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- cfg_access_time  in  PW  cycles from issue to read completion
- cfg_cycle_time  in  PW  minimum cycles between issues
- cfg_credits  in  NPART*PW  per-partition credits per frame; partition p at [p*PW +: PW]
- cfg_frame_len  in  PW  cycles per GSF frame
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle (valid&&ready)
- req_partitionid  in  log2(NPART)  requesting partition
- req_tid  in  TIDW  requesting thread
- req_writeback  in  1  1 = writeback (no completion), 0 = read miss
- req_addr  in  32  line address (statistics only)
- resp_valid  out  1  read completion strobe, one cycle
- resp_tid  out  TIDW  thread of the completing read
- resp_partitionid  out  log2(NPART)  partition of the completing read
- issue_valid  out  1  a request was issued to the channel this cycle
- issue_partitionid  out  log2(NPART)  partition issued
- issue_writeback  out  1  issued request was a writeback
- part_blocked  out  NPART  bit p=1: queue p non-empty and credit p == 0

Behaviour:
- Clock and reset: one clock gclk; rstn is asynchronous, active-low. Reset empties all queues and the in-flight FIFO, and zeroes credits, busy counter, frame counter, timestamp and the round-robin pointer. All outputs are 0 during reset; req_ready is 1 the cycle after release.
- req_ready is combinational: 1 iff the queue for req_partitionid is not full. A push and a pop of the same queue in one cycle are legal; req_ready is evaluated on pre-pop occupancy.
- Frame counter: counts 0..max(cfg_frame_len,1)-1 and wraps. On any cycle with frame_cnt==0, every credit[p] reloads from cfg_credits[p]; the first cycle after reset is therefore a reload cycle.
- Busy counter: loaded with max(cfg_cycle_time,1)-1 on issue and decremented to 0. The channel is idle iff busy==0.
- Eligibility: partition p is eligible iff its queue is non-empty and its effective credit > 0. Effective credit is the reload value on a reload cycle, otherwise the current credit.
- Issue occurs when the channel is idle, at least one partition is eligible, and, if the head of the chosen queue is a read, the in-flight FIFO is not full. A full in-flight FIFO blocks only read heads; a writeback head may still issue.
- Arbitration: round-robin starting at rr_ptr. After an issue, rr_ptr = issued partition + 1, modulo NPART.
- On issue: pop the head; credit[p] = effective credit - 1 (a reload and an issue in the same cycle yields cfg_credits[p]-1). Assert issue_* for exactly 1 cycle.
- Read issue pushes {tid, partitionid, due = ts + max(cfg_access_time,1)} into the in-flight FIFO. ts is a free-running TSW-bit counter; the due value wraps modulo 2^TSW.
- Completion: when the in-flight FIFO head has due==ts, it is popped and resp_* asserts for 1 cycle. Completions are therefore in issue order.
- Latency: read issued in cycle t -> resp_valid in cycle t+access_time. An issue and a completion in the same cycle are both performed.
- Credit 0: a partition with credit 0 stays queued until the next reload, with part_blocked[p]=1; no work-conserving borrowing. cfg_credits[p]==0 starves p permanently.
- Configuration may change at any time; new values take effect at the next load of each counter.
- Reset mid-operation discards queued and in-flight requests with no responses.

Test Plan:
- Single read: cycle_time=4, access_time=20, credits all 8, frame_len=100; read tid 5, partition 2 -> issue_valid the cycle after acceptance; resp_valid with tid 5 exactly 20 cycles after issue.
- Pacing: 4 reads from partition 0 back-to-back, cycle_time=4 -> issues spaced exactly 4 cycles apart; credit[0] ends at 4.
- Round-robin: partitions 1, 3, 6 each queue 2 reads, cycle_time=1 -> issue order 1,3,6,1,3,6.
- Credit exhaustion: credits[0]=2, frame_len=50; 5 reads from partition 0 at cycle 1 -> 2 issues, part_blocked[0]=1 until frame_cnt wraps at cycle 50; the next issue is in the reload cycle, leaving credit 1.
- Backpressure and writeback: fill partition 4 queue to 4 -> req_ready=0 for partition 4 while req_ready=1 for partition 5. With the in-flight FIFO full (8 reads, access_time=200, cycle_time=1), a writeback head still issues with no resp; reads wait.
- Async reset asserted mid-flight with 3 in-flight reads -> all outputs 0 immediately; no resp_valid after release; the first post-reset request issues normally.
